reg_file_wr_pipe: RTL and testbench
===================================

Name: reg_file_wr_pipe

Overview:
- Parametrised successor to the 3-to-8 write-enable decode stage of the register file.
- Owns a storage array of NUM_REGS words. Writes pass through one registered staging stage; the block exposes the staged one-hot row enable as to_reg.
- Provides two combinational read ports, with bypass from the staged write.
- Sits between the ALU/multiplier result bus and the operand read path.

Parameters:
- DATA_W, 32, word width in bits
- ADDR_W, 3, address width in bits
- NUM_REGS, 8, number of implemented registers; must satisfy 1 <= NUM_REGS <= 2^ADDR_W
- ZERO_REG, 0, 1 = register 0 is hard-wired to zero: writes to it are dropped and reads of it return 0

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- we  in  1  write request, sampled at clk rise
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- ra0  in  ADDR_W  read port 0 address
- ra1  in  ADDR_W  read port 1 address
- rd0  out  DATA_W  read port 0 data, combinational
- rd1  out  DATA_W  read port 1 data, combinational
- to_reg  out  NUM_REGS  registered one-hot row enable of the staged write
- wr_err  out  1  one-cycle pulse for a dropped write
- busy  out  1  high while a staged write is pending commit

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- While reset_n=0:
  - all array words = 0
  - pend_valid = 0, pend_addr = 0, pend_data = 0
  - to_reg = 0, wr_err = 0, busy = 0
  - Reset asserted mid-operation discards any staged write; nothing is committed.
- Accept, edge N:
  - If we=1 and the address is legal, then pend_valid<=1, pend_addr<=wr_addr, pend_data<=wr_data.
  - Legal address: wr_addr < NUM_REGS, and not (ZERO_REG=1 and wr_addr=0).
- Drop, edge N:
  - If we=1 and the address is illegal, pend_valid<=0 and wr_err<=1 for exactly one cycle.
  - No array state changes.
- Commit, edge N+1:
  - If pend_valid=1, then array[pend_addr] <= pend_data.
  - Write-to-array latency is 2 edges from sampling we.
- Pipeline register:
  - pend_valid<=0 on any edge where no legal write is accepted.
  - Back-to-back writes are fully pipelined, one per cycle. Each edge commits the previous staged write and stages the new one.
  - Same-address back-to-back writes: later data wins after both commits.
- to_reg:
  - to_reg[i] = pend_valid && pend_addr==i. At most one bit is set.
  - to_reg is 0 when pend_valid=0.
- busy = pend_valid.
- wr_err = 0 on any edge without a dropped write.
- Read, per port p:
  - If ZERO_REG=1 and ra_p=0: rdp=0.
  - Else if ra_p >= NUM_REGS: rdp=0.
  - Else if pend_valid and ra_p==pend_addr: rdp=pend_data (bypass).
  - Else: rdp=array[ra_p].
  - The in-flight input (we, wr_data) in the current cycle is NOT bypassed. A read of the same address in the sampling cycle returns the old value.
  - Both ports may address the same register; both return identical data.
- Widths: no arithmetic; the address compare uses the full ADDR_W, with no truncation.

Test Plan:
- Reset and idle:
  - Stimulus: assert reset_n=0 with we=1, wr_addr=3, wr_data=32'hDEAD_BEEF; then release reset.
  - Required: to_reg=0, busy=0, wr_err=0, and rd0 for ra0=0..7 reads 0.
- Latency and bypass:
  - Stimulus: we=1, wr_addr=5, wr_data=32'h1234_5678 at edge N; ra0=5.
  - Required: before edge N, rd0=0. After N, to_reg=8'b0010_0000, busy=1, rd0=32'h1234_5678 via bypass. After N+1, busy=0 and rd0=32'h1234_5678 from the array.
- Back-to-back same address:
  - Stimulus: writes to addr 2 with 32'hA, 32'hB, 32'hC on consecutive edges, then idle.
  - Required: to_reg=8'b0000_0100 for three cycles; ra1=2 reads A, B, C in successive cycles; final array[2]=32'hC.
- Zero register:
  - Stimulus: ZERO_REG=1; we=1, wr_addr=0, wr_data=32'hFFFF_FFFF.
  - Required: wr_err pulses for 1 cycle, to_reg=0, busy=0, rd0(ra0=0)=0.
- Out of range:
  - Stimulus: NUM_REGS=6; write addr 7 with data 32'h55.
  - Required: wr_err=1 for one cycle, no commit, rd0(ra0=7)=0.
  - Stimulus: then write addr 5 with data 32'h66.
  - Required: commits normally.
- Reset mid-write:
  - Stimulus: stage a write to addr 4 with data 32'h99, then assert reset_n=0 before the commit edge.
  - Required: to_reg=0 immediately, and array[4]=0 after reset is released.

Source files
------------

// File: rtl/reg_file_wr_pipe.sv
// Register file with a one-stage registered write pipeline and two combinational
// read ports that bypass the staged (not yet committed) write.
module reg_file_wr_pipe #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8,
    parameter int ZERO_REG = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                we,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0]   ra0,
    input  logic [ADDR_W-1:0]   ra1,
    output logic [DATA_W-1:0]   rd0,
    output logic [DATA_W-1:0]   rd1,
    output logic [NUM_REGS-1:0] to_reg,
    output logic                wr_err,
    output logic                busy
);

    // One extra bit so NUM_REGS == 2**ADDR_W still fits in the limit.
    localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0] mem [NUM_REGS];
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;
    logic              wr_legal;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < REG_LIMIT) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (addr_ok(a)) begin
            if (pend_valid && (a == pend_addr)) begin
                v = pend_data;
            end else begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (a == ADDR_W'(i)) begin
                        v = mem[i];
                    end
                end
            end
        end
        return v;
    endfunction

    assign wr_legal = we && addr_ok(wr_addr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
            wr_err     <= 1'b0;
        end else begin
            pend_valid <= wr_legal;
            wr_err     <= we && !wr_legal;
            if (wr_legal) begin
                pend_addr <= wr_addr;
                pend_data <= wr_data;
            end
        end
    end

    // Commit uses the staged row enable, so the array sees exactly what to_reg shows.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (to_reg[i]) begin
                    mem[i] <= pend_data;
                end
            end
        end
    end

    always_comb begin
        to_reg = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            to_reg[i] = pend_valid && (pend_addr == ADDR_W'(i));
        end
    end

    assign busy = pend_valid;
    assign rd0  = read_port(ra0);
    assign rd1  = read_port(ra1);

endmodule

// File: tb/tb_reg_file_wr_pipe.sv
// Scoreboard bench for reg_file_wr_pipe: dut_a uses defaults, dut_b has
// NUM_REGS=6 with register 0 hard-wired to zero.
module tb_reg_file_wr_pipe;

    typedef struct {
        int          cyc;
        bit          sel;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [7:0]  to_reg;
        logic        wr_err;
        logic        busy;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        we_a = 1'b0, we_b = 1'b0;
    logic [2:0]  wr_addr_a = '0, wr_addr_b = '0;
    logic [31:0] wr_data_a = '0, wr_data_b = '0;
    logic [2:0]  ra0_a = '0, ra1_a = '0, ra0_b = '0, ra1_b = '0;
    logic [31:0] rd0_a, rd1_a, rd0_b, rd1_b;
    logic [7:0]  to_reg_a;
    logic [5:0]  to_reg_b;
    logic        wr_err_a, wr_err_b, busy_a, busy_b;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    reg_file_wr_pipe dut_a (
        .clk(clk), .reset_n(reset_n), .we(we_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .ra0(ra0_a), .ra1(ra1_a), .rd0(rd0_a), .rd1(rd1_a), .to_reg(to_reg_a),
        .wr_err(wr_err_a), .busy(busy_a)
    );

    reg_file_wr_pipe #(.NUM_REGS(6), .ZERO_REG(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .we(we_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .ra0(ra0_b), .ra1(ra1_b), .rd0(rd0_b), .rd1(rd1_b), .to_reg(to_reg_b),
        .wr_err(wr_err_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Drives one cycle of inputs and queues the outputs expected mid-way through that cycle.
    task automatic applyStimulus(input bit sel, input logic rst, input logic we,
                                 input logic [2:0] wa, input logic [31:0] wd,
                                 input logic [2:0] r0, input logic [2:0] r1,
                                 input logic [31:0] e_rd0, input logic [31:0] e_rd1,
                                 input logic [7:0] e_to, input logic e_err, input logic e_busy,
                                 input string name);
        exp_t e;
        @(posedge clk);
        #2;
        reset_n = rst;
        if (sel == 1'b0) begin
            we_a = we; wr_addr_a = wa; wr_data_a = wd; ra0_a = r0; ra1_a = r1; we_b = 1'b0;
        end else begin
            we_b = we; wr_addr_b = wa; wr_data_b = wd; ra0_b = r0; ra1_b = r1; we_a = 1'b0;
        end
        e.cyc = cyc; e.sel = sel; e.rd0 = e_rd0; e.rd1 = e_rd1; e.to_reg = e_to;
        e.wr_err = e_err; e.busy = e_busy; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [31:0] a_rd0, a_rd1;
        logic [7:0]  a_to;
        logic        a_err, a_busy;
        if (e.sel == 1'b0) begin
            a_rd0 = rd0_a; a_rd1 = rd1_a; a_to = to_reg_a; a_err = wr_err_a; a_busy = busy_a;
        end else begin
            a_rd0 = rd0_b; a_rd1 = rd1_b; a_to = {2'b00, to_reg_b}; a_err = wr_err_b; a_busy = busy_b;
        end
        checks++;
        if (a_rd0 !== e.rd0 || a_rd1 !== e.rd1 || a_to !== e.to_reg ||
            a_err !== e.wr_err || a_busy !== e.busy) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d: got rd0=%h rd1=%h to_reg=%b wr_err=%b busy=%b, want rd0=%h rd1=%h to_reg=%b wr_err=%b busy=%b",
                     e.name, e.cyc, a_rd0, a_rd1, a_to, a_err, a_busy,
                     e.rd0, e.rd1, e.to_reg, e.wr_err, e.busy);
        end
    endtask

    // Monitor: mid-cycle, pop every expectation queued for this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s: sample missed, queued cyc=%0d now cyc=%0d", e.name, e.cyc, cyc);
            end else begin
                checkOutput(e);
            end
        end
    end

    initial begin
        // Reset with a pending-looking write on the inputs, then release.
        applyStimulus(0, 0, 1, 3, 32'hDEAD_BEEF, 3, 3, 0, 0, 8'h00, 0, 0, "rst_hold");
        applyStimulus(0, 0, 1, 3, 32'hDEAD_BEEF, 3, 0, 0, 0, 8'h00, 0, 0, "rst_hold2");
        applyStimulus(0, 1, 0, 0, 0, 3, 3, 0, 0, 8'h00, 0, 0, "rst_release");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 3'(i), 3'(7 - i), 0, 0, 8'h00, 0, 0, "rst_read");
        end

        // Latency and bypass.
        applyStimulus(0, 1, 0, 0, 0, 5, 0, 0, 0, 8'h00, 0, 0, "lat_idle");
        applyStimulus(0, 1, 1, 5, 32'h1234_5678, 5, 0, 0, 0, 8'h00, 0, 0, "lat_no_inflight_bypass");
        applyStimulus(0, 1, 0, 0, 0, 5, 0, 32'h1234_5678, 0, 8'h20, 0, 1, "lat_bypass");
        applyStimulus(0, 1, 0, 0, 0, 5, 0, 32'h1234_5678, 0, 8'h00, 0, 0, "lat_commit");

        // Back-to-back writes to register 2.
        applyStimulus(0, 1, 1, 2, 32'hA, 5, 2, 32'h1234_5678, 0,     8'h00, 0, 0, "b2b_1");
        applyStimulus(0, 1, 1, 2, 32'hB, 5, 2, 32'h1234_5678, 32'hA, 8'h04, 0, 1, "b2b_2");
        applyStimulus(0, 1, 1, 2, 32'hC, 5, 2, 32'h1234_5678, 32'hB, 8'h04, 0, 1, "b2b_3");
        applyStimulus(0, 1, 0, 0, 0,     5, 2, 32'h1234_5678, 32'hC, 8'h04, 0, 1, "b2b_4");
        applyStimulus(0, 1, 0, 0, 0,     5, 2, 32'h1234_5678, 32'hC, 8'h00, 0, 0, "b2b_final");

        // Distinct addresses, both ports, and register 0 writable on dut_a.
        applyStimulus(0, 1, 1, 7, 32'h77, 7, 2, 0,      32'hC,  8'h00, 0, 0, "mix_1");
        applyStimulus(0, 1, 1, 1, 32'h11, 7, 7, 32'h77, 32'h77, 8'h80, 0, 1, "mix_same_addr");
        applyStimulus(0, 1, 0, 0, 0,      1, 7, 32'h11, 32'h77, 8'h02, 0, 1, "mix_3");
        applyStimulus(0, 1, 0, 0, 0,      0, 1, 0,      32'h11, 8'h00, 0, 0, "mix_4");
        applyStimulus(0, 1, 1, 0, 32'hF0, 0, 1, 0,      32'h11, 8'h00, 0, 0, "r0_wr");
        applyStimulus(0, 1, 0, 0, 0,      0, 1, 32'hF0, 32'h11, 8'h01, 0, 1, "r0_staged");
        applyStimulus(0, 1, 0, 0, 0,      0, 1, 32'hF0, 32'h11, 8'h00, 0, 0, "r0_commit");

        // Zero register on dut_b.
        applyStimulus(1, 1, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 8'h00, 0, 0, "zero_wr");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, "zero_err");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, "zero_err_clear");

        // Out of range on dut_b (NUM_REGS=6).
        applyStimulus(1, 1, 1, 7, 32'h55, 7, 5, 0, 0,      8'h00, 0, 0, "oor_wr7");
        applyStimulus(1, 1, 1, 5, 32'h66, 7, 5, 0, 0,      8'h00, 1, 0, "oor_err7");
        applyStimulus(1, 1, 1, 6, 32'h77, 6, 5, 0, 32'h66, 8'h20, 0, 1, "oor_stage5");
        applyStimulus(1, 1, 0, 0, 0,      7, 5, 0, 32'h66, 8'h00, 1, 0, "oor_err6");
        applyStimulus(1, 1, 0, 0, 0,      6, 5, 0, 32'h66, 8'h00, 0, 0, "oor_commit5");

        // Reset mid-write on dut_a.
        applyStimulus(0, 1, 1, 4, 32'h99, 4, 2, 0, 32'hC, 8'h00, 0, 0, "rmw_stage");
        applyStimulus(0, 0, 0, 0, 0,      4, 2, 0, 0,     8'h00, 0, 0, "rmw_reset");
        applyStimulus(0, 1, 0, 0, 0,      4, 2, 0, 0,     8'h00, 0, 0, "rmw_release");
        applyStimulus(0, 1, 0, 0, 0,      4, 0, 0, 0,     8'h00, 0, 0, "rmw_after");

        for (int i = 0; i < 5; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d expectations never sampled, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
